// File: rtl/vertical_timing.sv
// Vertical VGA timing: counts lines on each hsync falling edge and derives
// vsync, the visible row address and window, the video enable and a frame tick.
module vertical_timing #(
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC       = 2,
  parameter int V_DISP_START = 35,
  parameter int V_DISP_END   = 515,
  parameter int VDIV_LOG2    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       hdisplay,
  output logic       vsync,
  output logic [9:0] vaddr,
  output logic       vdisplay,
  output logic       video_on,
  output logic       frame_tick,
  output logic [9:0] line
);

  localparam logic [9:0] LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] SYNC_END   = 10'(V_SYNC);
  localparam logic [9:0] DISP_START = 10'(V_DISP_START);
  localparam logic [9:0] DISP_END   = 10'(V_DISP_END);

  logic       hsync_d;
  logic       line_start;
  logic       wrap;
  logic [9:0] line_next;
  logic [9:0] row;
  logic [9:0] vaddr_next;
  logic       vsync_next;
  logic       vdisplay_next;

  // Falling hsync marks the horizontal counter wrapping back to 0.
  assign line_start = hsync_d & ~hsync;
  assign wrap       = (line == LAST);

  // Derived outputs are taken from the line value about to be loaded.
  always_comb begin
    line_next     = wrap ? 10'd0 : line + 10'd1;
    vsync_next    = (line_next >= SYNC_END);
    vdisplay_next = (line_next >= DISP_START) && (line_next < DISP_END);
    row           = line_next - DISP_START;
    vaddr_next    = vdisplay_next ? (row >> VDIV_LOG2) : 10'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_d    <= 1'b0;
      line       <= 10'd0;
      vsync      <= 1'b0;
      vdisplay   <= 1'b0;
      vaddr      <= 10'd0;
      video_on   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hsync_d    <= hsync;
      video_on   <= hdisplay & vdisplay;
      frame_tick <= line_start & wrap;
      if (line_start) begin
        line     <= line_next;
        vsync    <= vsync_next;
        vdisplay <= vdisplay_next;
        vaddr    <= vaddr_next;
      end
    end
  end

endmodule

// File: tb/tb_vertical_timing.sv
// Bench for vertical_timing: shortened 40-clock lines from a horizontal model,
// per-cycle scoreboard against a reference model plus directed frame checks.
module tb_vertical_timing;

  localparam int LINE    = 40;
  localparam int HS      = 8;
  localparam int V_TOTAL = 525;
  localparam int V_SYNC  = 2;
  localparam int VS      = 35;
  localparam int VE      = 515;

  logic       clk = 1'b0;
  logic       rst, hsync, hdisplay;
  logic       vsync, vdisplay, video_on, frame_tick;
  logic [9:0] vaddr, line;
  logic       vsync2, vdisplay2, video_on2, frame_tick2;
  logic [9:0] vaddr2, line2;

  always #5 clk = ~clk;

  vertical_timing dut (
    .clk(clk), .rst(rst), .hsync(hsync), .hdisplay(hdisplay),
    .vsync(vsync), .vaddr(vaddr), .vdisplay(vdisplay),
    .video_on(video_on), .frame_tick(frame_tick), .line(line)
  );

  vertical_timing #(.VDIV_LOG2(1)) dut2 (
    .clk(clk), .rst(rst), .hsync(hsync), .hdisplay(hdisplay),
    .vsync(vsync2), .vaddr(vaddr2), .vdisplay(vdisplay2),
    .video_on(video_on2), .frame_tick(frame_tick2), .line(line2)
  );

  typedef struct {
    logic [9:0] line;
    logic [9:0] vaddr;
    logic [9:0] vaddr2;
    logic       vsync;
    logic       vdisplay;
    logic       video_on;
    logic       frame_tick;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  int m_line, m_va, m_va2;
  bit m_hd, m_vs, m_vd, m_von, m_ft;
  bit rst_req;
  int hcnt, cyc, last_ft, n_ft, period, max_va2;
  int fr_vs, fr_vd, fr_von, p_vs, p_vd, p_von;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic void set_derived();
    m_vs  = (m_line >= V_SYNC);
    m_vd  = (m_line >= VS) && (m_line < VE);
    m_va  = m_vd ? (m_line - VS) : 0;
    m_va2 = m_vd ? (m_line - VS) / 2 : 0;
  endfunction

  function automatic void model_reset();
    m_line = 0;
    m_hd   = 1'b0;
    m_von  = 1'b0;
    m_ft   = 1'b0;
    set_derived();
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, "_line"},  line, 10'd0);
    chk({tag, "_vsync"}, 10'(vsync), 10'd0);
    chk({tag, "_vdisp"}, 10'(vdisplay), 10'd0);
    chk({tag, "_vaddr"}, vaddr, 10'd0);
    chk({tag, "_von"},   10'(video_on), 10'd0);
    chk({tag, "_ft"},    10'(frame_tick), 10'd0);
  endtask

  // One clock: drive at negedge, push the model's expectation, compare after posedge.
  task automatic tick(input int hs_ovr = -1);
    exp_t e;
    bit   ls;
    @(negedge clk);
    rst      = rst_req;
    hsync    = (hs_ovr >= 0) ? hs_ovr[0] : (hcnt >= HS);
    hdisplay = ((m_line == 10) || (m_line == 100)) && (hcnt >= 20) && (hcnt < 30);
    if (rst) begin
      model_reset();
    end else begin
      ls    = m_hd && !hsync;
      m_von = hdisplay && m_vd;
      m_ft  = ls && (m_line == V_TOTAL - 1);
      if (ls) begin
        m_line = (m_line == V_TOTAL - 1) ? 0 : m_line + 1;
        set_derived();
      end
      m_hd = hsync;
    end
    e.line = 10'(m_line);  e.vaddr = 10'(m_va);  e.vaddr2 = 10'(m_va2);
    e.vsync = m_vs;  e.vdisplay = m_vd;  e.video_on = m_von;  e.frame_tick = m_ft;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("line",   line,   e.line);
    chk("vsync",  10'(vsync),    10'(e.vsync));
    chk("vdisp",  10'(vdisplay), 10'(e.vdisplay));
    chk("vaddr",  vaddr,  e.vaddr);
    chk("von",    10'(video_on),   10'(e.video_on));
    chk("ftick",  10'(frame_tick), 10'(e.frame_tick));
    chk("line2",  line2,  e.line);
    chk("vaddr2", vaddr2, e.vaddr2);
    chk("vsync2", 10'(vsync2),    10'(e.vsync));
    chk("vdisp2", 10'(vdisplay2), 10'(e.vdisplay));
    chk("von2",   10'(video_on2),   10'(e.video_on));
    chk("ftick2", 10'(frame_tick2), 10'(e.frame_tick));
    // Frame statistics from observed outputs only.
    if (int'(vaddr2) > max_va2) max_va2 = int'(vaddr2);
    if (frame_tick === 1'b1) begin
      if (n_ft > 0) begin
        period = cyc - last_ft;
        p_vs = fr_vs;  p_vd = fr_vd;  p_von = fr_von;
      end
      n_ft++;
      last_ft = cyc;
      fr_vs = 0;  fr_vd = 0;  fr_von = 0;
    end
    if (vsync === 1'b0)    fr_vs++;
    if (vdisplay === 1'b1) fr_vd++;
    if (video_on === 1'b1) fr_von++;
    if (!rst) hcnt = (hcnt + 1) % LINE;
    cyc++;
  endtask

  task automatic wait_line(input int target, input int budget);
    int n = 0;
    while (line !== 10'(target) && n < budget) begin
      tick();
      n++;
    end
    total++;
    assert (n < budget) else begin
      bad++;
      $error("FAIL wait_line got=%0d exp=%0d (timeout)", line, target);
    end
  endtask

  initial begin
    int ft_before;
    rst = 1'b1;  rst_req = 1'b1;  hsync = 1'b0;  hdisplay = 1'b0;
    hcnt = 0;  cyc = 0;  n_ft = 0;  last_ft = 0;  period = 0;  max_va2 = 0;
    fr_vs = 0;  fr_vd = 0;  fr_von = 0;  p_vs = 0;  p_vd = 0;  p_von = 0;
    model_reset();
    #6;
    chk_reset_values("reset");
    repeat (3) tick();
    rst_req = 1'b0;

    // First wrap and vsync release
    repeat (LINE) tick();
    chk("pre_first_wrap", line, 10'd0);
    tick();
    chk("first_wrap", line, 10'd1);
    repeat (LINE - 1) tick();
    chk("vsync_before_line2", 10'(vsync), 10'd0);
    tick();
    chk("vsync_rise", 10'(vsync), 10'd1);
    chk("vsync_rise_line", line, 10'd2);

    // Visible window edges, both divider settings
    wait_line(VS, V_TOTAL * LINE);
    chk("win_open_vdisp", 10'(vdisplay), 10'd1);
    chk("win_open_vaddr", vaddr, 10'd0);
    wait_line(36, 2 * LINE);
    chk("div2_line36", vaddr2, 10'd0);
    wait_line(37, 2 * LINE);
    chk("div2_line37", vaddr2, 10'd1);
    wait_line(514, V_TOTAL * LINE);
    chk("last_vis_vaddr", vaddr, 10'd479);
    chk("last_vis_vaddr2", vaddr2, 10'd239);
    wait_line(VE, 2 * LINE);
    chk("win_close_vdisp", 10'(vdisplay), 10'd0);
    chk("win_close_vaddr", vaddr, 10'd0);

    // Frame wrap and a second full frame
    wait_line(0, V_TOTAL * LINE);
    chk("wrap_ftick", 10'(frame_tick), 10'd1);
    chk("wrap_vsync", 10'(vsync), 10'd0);
    tick();
    chk("ftick_one_clock", 10'(frame_tick), 10'd0);
    wait_line(1, 2 * LINE);
    wait_line(0, V_TOTAL * LINE);
    chk("ftick_count", 10'(n_ft), 10'd2);
    total++;
    assert (period === V_TOTAL * LINE) else begin
      bad++;
      $error("FAIL frame_period got=%0d exp=%0d", period, V_TOTAL * LINE);
    end
    chk("vsync_low_clocks", 10'(p_vs), 10'(V_SYNC * LINE));
    total++;
    assert (p_vd === 480 * LINE) else begin
      bad++;
      $error("FAIL vdisp_clocks got=%0d exp=%0d", p_vd, 480 * LINE);
    end
    chk("video_on_clocks", 10'(p_von), 10'd10);
    chk("vaddr2_max", 10'(max_va2), 10'd239);

    // Asynchronous reset mid-frame
    wait_line(300, V_TOTAL * LINE);
    chk("pre_reset_vaddr", vaddr, 10'd265);
    rst_req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    hcnt = 0;
    #1;
    chk_reset_values("async_reset");
    repeat (5) tick();
    rst_req = 1'b0;
    ft_before = n_ft;
    repeat (LINE) tick();
    chk("restart_line0", line, 10'd0);
    tick();
    chk("restart_line1", line, 10'd1);
    chk("restart_no_ftick", 10'(n_ft), 10'(ft_before));

    // Unfiltered hsync pulses, then a long low period
    tick(1);
    tick(0);
    tick(1);
    tick(0);
    chk("glitch_two_adv", line, 10'd3);
    repeat (50) tick(0);
    chk("long_low_one_adv", line, 10'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
